// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction prefetch queue.
//   IW / AW / DEPTH : instruction width, PC width, default queue depth
//   inst_t, pc_t    : instruction word and program-counter types
//   fq_entry_t      : one queue entry, an instruction tagged with its PC
//   Q_EMPTY/Q_PARTIAL/Q_FULL : queue condition reported on the debug output
package fetch_pkg;

  localparam int IW    = 9;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  typedef logic [IW-1:0] inst_t;
  typedef logic [AW-1:0] pc_t;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fq_entry_t;

  // The queue has no FSM of its own; its condition is implied by occupancy
  // and exported under these encodings.
  localparam logic [1:0] Q_EMPTY   = 2'd0;
  localparam logic [1:0] Q_PARTIAL = 2'd1;
  localparam logic [1:0] Q_FULL    = 2'd2;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bus between the fetch queue, the instruction ROM and the
// control decoder.
//   slave  modport : the fetch queue itself (drives rom_addr and the head
//                    entry, receives ROM data and control)
//   master modport : the surrounding core / testbench
// Handshake: the head entry (inst, inst_pc) is offered whenever
// inst_valid=1; the decoder takes it by holding deq=1 during that cycle and
// it is consumed at the next posedge. deq while inst_valid=0 is ignored.
// rom_data must be the ROM word at rom_addr within the same cycle.
interface fetch_queue_if #(
  parameter int DEPTH = fetch_pkg::DEPTH
);
  import fetch_pkg::*;

  localparam int OW = $clog2(DEPTH + 1);

  logic          fetch_en;
  pc_t           rom_addr;
  inst_t         rom_data;
  logic          redirect;
  pc_t           redirect_pc;
  logic          deq;
  logic          inst_valid;
  inst_t         inst;
  pc_t           inst_pc;
  logic [OW-1:0] occupancy;
  logic [1:0]    q_state;

  modport slave (
    input  fetch_en, rom_data, redirect, redirect_pc, deq,
    output rom_addr, inst_valid, inst, inst_pc, occupancy, q_state
  );

  modport master (
    output fetch_en, rom_data, redirect, redirect_pc, deq,
    input  rom_addr, inst_valid, inst, inst_pc, occupancy, q_state
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fq_entry_t with head/tail/count pointers.
//   clk, rst    : clock, synchronous active-high reset
//   push/push_data : write an entry at the tail
//   pop         : advance the head (ignored when empty)
//   flush       : discard all entries (overrides push/pop)
//   head_data   : oldest entry, zero when empty
//   full/empty/count : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  input  logic          flush,
  output fq_entry_t     head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Storage is never cleared; an empty queue masks the head to zero instead.
  assign head_data = empty ? '0 : mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_ok  = pop & ~empty;
    // A push into a full buffer is legal only when the head leaves together.
    push_ok = push & (~full | pop_ok);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PW'(1);
      end
      if (pop_ok) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between the instruction ROM and
// the control decoder.
//   CLK   : clock, all state changes on posedge
//   start : synchronous active-high reset/init, overrides every other input
//   fq    : fetch_queue_if.slave (ROM address/data, redirect, decoder head)
// Owns the fetch pointer fpc (driven straight onto rom_addr), the redirect
// flush and the optional bypass path.
// Build option FETCH_BYPASS_EN: when the queue is empty and fetching is
// allowed, the ROM word is presented to the decoder in the same cycle
// (zero-cycle latency after a redirect). Without it the first word after a
// reset or redirect appears one cycle later and rom_data never reaches inst
// combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = fetch_pkg::DEPTH
) (
  input logic           CLK,
  input logic           start,
  fetch_queue_if.slave  fq
);

  localparam int CW = $clog2(DEPTH + 1);

  pc_t           fpc_q, fpc_d;
  fq_entry_t     fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          bypass_act;
  logic          head_valid;
  logic          deq_eff;
  logic          enq;
  logic          push;
  logic          pop;

  always_comb begin
`ifdef FETCH_BYPASS_EN
    bypass_act = fifo_empty & fq.fetch_en & ~fq.redirect;
`else
    bypass_act = 1'b0;
`endif
    head_valid = ~fifo_empty | bypass_act;
    deq_eff    = fq.deq & head_valid;
    enq        = fq.fetch_en & ~fq.redirect & (~fifo_full | deq_eff);
    // A bypassed word taken by the decoder in the same cycle is never stored.
    push       = enq & ~(bypass_act & deq_eff);
    pop        = deq_eff & ~fifo_empty;

    fpc_d = fpc_q;
    if (fq.redirect) begin
      fpc_d = fq.redirect_pc;
    end else if (enq) begin
      fpc_d = fpc_q + AW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      fpc_q <= '0;
    end else begin
      fpc_q <= fpc_d;
    end
  end

  // The redirect flush also swallows any same-cycle pop: the head is
  // consumed before the flush and nothing else survives.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (start),
    .push      (push),
    .push_data ('{inst: fq.rom_data, pc: fpc_q}),
    .pop       (pop),
    .flush     (fq.redirect),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fq.rom_addr   = fpc_q;
  assign fq.inst_valid = head_valid;
  assign fq.inst       = bypass_act ? fq.rom_data : fifo_head.inst;
  assign fq.inst_pc    = bypass_act ? fpc_q       : fifo_head.pc;
  assign fq.occupancy  = fifo_count;
  assign fq.q_state    = (fifo_count == '0)          ? Q_EMPTY :
                         (fifo_count == CW'(DEPTH))  ? Q_FULL  : Q_PARTIAL;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue between the instruction ROM and the control decoder.
- Drives the ROM address from its own fetch pointer and buffers up to DEPTH fetched 9-bit instructions, each tagged with its PC.
- Presents the oldest buffered instruction to the decoder.
- Flushes and refetches from a new address on any taken jump or branch redirect.

Parameters:
- IW, 9, instruction width.
- AW, 10, PC / ROM address width.
- DEPTH, 4, queue entries (power of two, ≥2).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- start  input  1  synchronous active-high reset/init.
- fetch_en  input  1  permits enqueue this cycle (low while halted).
- rom_addr  output  AW  address to instruction ROM (combinational ROM read).
- rom_data  input  IW  instruction at rom_addr, same cycle.
- redirect  input  1  taken jump/branch; flush queue.
- redirect_pc  input  AW  new fetch address when redirect=1.
- deq  input  1  decoder consumes head entry this cycle.
- inst_valid  output  1  head entry present.
- inst  output  IW  head instruction.
- inst_pc  output  AW  PC of head instruction.
- occupancy  output  $clog2(DEPTH+1)  entries currently held.

Behaviour:
- Reset (start=1 at posedge):
  - fetch pointer fpc=0; queue empty; occupancy=0; inst_valid=0.
  - inst and inst_pc = 0 when empty.
  - start overrides every other input, including mid-flush and when full.
- rom_addr = fpc at all times.
- Enqueue condition: fetch_en & ~redirect & (occupancy<DEPTH | deq_eff).
  - On enqueue, {rom_data, fpc} is written at the tail and fpc <= fpc+1.
  - fpc wraps modulo 2^AW (1023 → 0).
- deq_eff = deq & inst_valid. A deq on an empty queue is ignored and does not change state.
- Occupancy update:
  - Enqueue and deq_eff together (including when full): occupancy unchanged; head advances, tail written.
  - Enqueue only: occupancy +1.
  - deq_eff only: occupancy −1.
- Redirect (priority below start, above everything else):
  - All entries discarded; occupancy <= 0; fpc <= redirect_pc; no enqueue that cycle.
  - A deq asserted in the same cycle is treated as consuming the head before the flush; nothing else is retained.
- Latency (macro off): after reset or redirect, the first instruction is inst_valid on the next cycle.
- Steady state: with deq held high and fetch_en high, one instruction per cycle, in order.
- fetch_en=0: no enqueue and fpc holds; deq continues to drain.
- Internal storage is circular head/tail pointers, each of width $clog2(DEPTH), wrapping at DEPTH.
- There is no state machine beyond the pointers. The states are implied by occupancy: EMPTY (0), PARTIAL, FULL (DEPTH).

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty and fetch_en & ~redirect, inst_valid=1 combinationally and inst/inst_pc = rom_data/fpc.
  - A deq in that cycle consumes the word directly: fpc advances and nothing is stored. This gives zero-cycle fetch latency after a redirect.
- Undefined: no combinational path from rom_data to inst; one-cycle latency as above.

Decomposition:
- Package fetch_pkg:
  - IW/AW localparams.
  - typedef inst_t (logic[8:0]), pc_t (logic[9:0]).
  - packed struct fq_entry_t {inst_t inst; pc_t pc;}.
- One natural sub-module: fetch_fifo.
  - Parameterised storage array of fq_entry_t plus head/tail/count logic.
  - Provides push/pop/flush inputs and full/empty outputs.
- fetch_queue wraps fetch_fifo and owns fpc, redirect priority and the bypass path.

Test Plan:
- Reset: start=1 for 2 cycles → occupancy=0, inst_valid=0, rom_addr=0. Release, deq=0 → after 4 cycles occupancy=4, rom_addr=4, further cycles keep rom_addr=4.
- Streaming: ROM[k]=k+0x100, deq=1 continuously → inst_pc sequence 0,1,2,3… and inst=0x100,0x101,… with no gaps after the first valid cycle.
- Full with simultaneous deq: occupancy=4, deq=1 → occupancy stays 4, head advances by 1, new tail PC=4.
- Redirect: occupancy=3, redirect=1, redirect_pc=0x2A0, deq=1 → next cycle occupancy=0, rom_addr=0x2A0; following cycle inst_pc=0x2A0 (FETCH_BYPASS_EN: valid in the same cycle as the flush completes).
- Wrap and empty deq: redirect_pc=0x3FE, deq=1 → inst_pc 0x3FE,0x3FF,0x000. Separately, deq=1 while empty → occupancy remains 0, no pointer change.
- Reset mid-operation: occupancy=2 with fetch_en=1, assert start for 1 cycle → next cycle occupancy=0, rom_addr=0, inst_valid=0.
